// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the PC-generator, instruction-memory and IF/ID signals of the
// instruction-fetch sequencer.
//   master : the fetch unit side (drives pc_write, imem_req_*, id_*)
//   slave  : the surrounding pipeline / memory side
// Signals:
//   pc_in, pc_write                   PC generator link
//   flush                             redirect from branch resolution
//   imem_req_valid/ready/addr         request channel to instruction memory
//   imem_rsp_valid/data               response channel from instruction memory
//   id_valid/ready/pc/instr           IF/ID register toward decode
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_write;
  logic               flush;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output pc_write, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  pc_write, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// IF-stage fetch sequencer. Issues at most one instruction-memory request at
// a time for the current PC, loads each returned instruction with its PC into
// the one-deep IF/ID register, produces the PC-advance enable, and discards
// in-flight responses after a flush.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        if_fetch_unit_if.master (PC link, imem req/rsp, IF/ID outputs)
//   perf_fetch_cnt, perf_stall_cnt  only when IF_FETCH_PERF_EN is defined:
//              responses loaded into IF/ID, and cycles IF/ID is stalled
// Optional feature macro: IF_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [ADDR_W-1:0]  req_pc_r;
  logic               id_valid_r;
  logic [ADDR_W-1:0]  id_pc_r;
  logic [INSTR_W-1:0] id_instr_r;

  logic               out_free_s;
  logic               req_valid_s;
  logic               pc_write_s;
  logic               accept_s;
  logic               load_s;

  assign out_free_s = !id_valid_r || bus.id_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, request handshake and PC-advance enable
  always_comb begin
    state_s     = state_r;
    req_valid_s = 1'b0;
    pc_write_s  = 1'b0;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      // A flush always lets the PC generator load the redirect target.
      pc_write_s = bus.flush;
      case (state_r)
        IDLE: begin
          req_valid_s = out_free_s && !bus.flush;
          if (req_valid_s && bus.imem_req_ready) begin
            accept_s   = 1'b1;
            pc_write_s = 1'b1;
            state_s    = WAIT_RSP;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_RSP: begin
          if (bus.flush) begin
            // Response in the flush cycle is dropped; otherwise wait it out.
            state_s = bus.imem_rsp_valid ? IDLE : DRAIN;
          end else if (bus.imem_rsp_valid) begin
            load_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_RSP;
          end
        end
        DRAIN: begin
          if (bus.flush) begin
            state_s = DRAIN;
          end else if (bus.imem_rsp_valid) begin
            state_s = IDLE;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Address of the outstanding request, tagged onto its response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_r <= '0;
    end else if (accept_s) begin
      req_pc_r <= bus.pc_in;
    end
  end

  // IF/ID register: flush beats load, load beats consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_r <= 1'b0;
      id_pc_r    <= '0;
      id_instr_r <= NOP_INSTR;
    end else if (bus.flush) begin
      id_valid_r <= 1'b0;
      id_instr_r <= NOP_INSTR;
    end else if (load_s) begin
      id_valid_r <= 1'b1;
      id_pc_r    <= req_pc_r;
      id_instr_r <= bus.imem_rsp_data;
    end else if (id_valid_r && bus.id_ready) begin
      id_valid_r <= 1'b0;
      id_instr_r <= NOP_INSTR;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_write       = pc_write_s;
  assign bus.id_valid       = id_valid_r;
  assign bus.id_pc          = id_pc_r;
  assign bus.id_instr       = id_instr_r;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (load_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (id_valid_r && !bus.id_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`endif

  if_fetch_unit_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .idle      (state_r == IDLE),
    .rsp_valid (bus.imem_rsp_valid)
  );

endmodule

// ---------------------------------------------------------------------------
// if_fetch_unit_chk
// Flags a memory response arriving while no request is outstanding.
// Ports: clk, rst, idle (sequencer in IDLE), rsp_valid (imem response valid)
// ---------------------------------------------------------------------------
module if_fetch_unit_chk (
  input logic clk,
  input logic rst,
  input logic idle,
  input logic rsp_valid
);
  a_no_rsp_in_idle : assert property (@(posedge clk) disable iff (rst) !(idle && rsp_valid));
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch sequencer placed directly downstream of the PC generator in the IF stage. It takes the current PC and issues at most one request at a time to instruction memory over a valid/ready request channel plus a response channel. It registers each returned instruction, with its PC, into the IF/ID output register toward decode. It also produces the PC-advance enable back to the PC generator and handles pipeline flushes, including discarding in-flight responses.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
INSTR_W, 32, instruction width
NOP_INSTR, 32'h0000_0013, value driven on id_instr when no valid instruction (RV32I addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset
pc_in  in  ADDR_W  current PC from the PC generator
pc_write  out  1  PC-advance enable to the PC generator
flush  in  1  redirect/flush from branch resolution
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address, always equals pc_in
imem_rsp_valid  in  1  response data valid, one cycle pulse per accepted request
imem_rsp_data  in  INSTR_W  fetched instruction
id_valid  out  1  IF/ID register holds a valid instruction
id_ready  in  1  decode consumes the IF/ID entry this cycle
id_pc  out  ADDR_W  PC of the held instruction
id_instr  out  INSTR_W  held instruction

Behaviour:
- Reset rst: asynchronous, active-high; clock clk.
- Reset values: state=IDLE, id_valid=0, id_pc=0, id_instr=NOP_INSTR, internal req_pc=0.
- imem_req_valid and pc_write are combinational and are 0 while rst=1.
- out_free = !id_valid || id_ready.
- FSM states: IDLE, WAIT_RSP, DRAIN.
- IDLE:
  - imem_req_valid = out_free && !flush.
  - On imem_req_valid && imem_req_ready: req_pc<=pc_in, pc_write=1, go WAIT_RSP.
  - Otherwise pc_write=0 and the FSM stays in IDLE.
- WAIT_RSP:
  - imem_req_valid=0.
  - On imem_rsp_valid with no flush: id_valid<=1, id_pc<=req_pc, id_instr<=imem_rsp_data, go IDLE.
  - Back-to-back issue is allowed: the next request can be accepted in the cycle after the response.
- DRAIN:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard the data, go IDLE.
- Flush, highest priority:
  - pc_write=1 in the flush cycle so the PC generator loads the redirect target, independent of state.
  - id_valid<=0 and id_instr<=NOP_INSTR in the next cycle.
  - IDLE: no request issued, stay IDLE.
  - WAIT_RSP with imem_rsp_valid in the same cycle: discard the response, go IDLE.
  - WAIT_RSP without imem_rsp_valid: go DRAIN.
  - DRAIN: stay DRAIN.
- IF/ID consumption: when id_valid && id_ready and no new response is loaded, id_valid<=0 and id_instr<=NOP_INSTR. A simultaneous consume and load takes the new entry.
- While id_valid && !id_ready, the IF/ID register holds and no new request is issued. The one-deep output register therefore never overflows.
- imem_rsp_valid arriving in IDLE is a protocol error. It is ignored and an assertion is raised in simulation.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1), id_valid high in cycle N+k+1. Peak throughput is 1 instruction per 2 cycles with k=1.

Optional Feature:
Macro: IF_FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each response loaded into IF/ID.
  - perf_stall_cnt increments on each cycle with id_valid && !id_ready.
- Undefined: the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst mid-WAIT_RSP. Required: next edge shows id_valid=0, id_instr=32'h13, imem_req_valid=0; after release, the first request has addr=pc_in.
- Single fetch: pc_in=0x100, ready=1, response of 0x00500093 one cycle later. Required: id_valid=1, id_pc=0x100, id_instr=0x00500093; pc_write pulsed exactly once.
- Back-pressure: id_ready=0 with id_valid=1. Required: imem_req_valid=0 and the held entry is unchanged for 5 cycles; on id_ready=1 a new request issues in the same cycle.
- Memory stall: imem_req_ready=0 for 3 cycles. Required: pc_write=0 and imem_req_addr stable during those cycles; on accept, exactly one PC advance.
- Flush in flight: flush during WAIT_RSP, response 2 cycles later with data 0xDEADBEEF. Required: DRAIN is entered, the data is discarded, id_valid stays 0, and the next request uses the redirected pc_in=0x200.
- Flush coincident with response: flush and imem_rsp_valid in the same cycle. Required: response dropped, state IDLE, id_valid=0 on the next cycle.
